// File: rtl/warp_fetch.sv
// Instruction fetch stage: owns the PC, issues one doubleword icache read at a time,
// and splits each response into two 32-bit instructions for decode. Optional macro: WARP_FETCH_MISALIGN_EN.
module warp_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_req_valid,
  output logic [63:0] o_req_raddr,
  input  logic        i_res_valid,
  input  logic [63:0] i_res_rdata,
  input  logic        i_redirect_valid,
  input  logic [63:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [63:0] o_inst_pc,
  input  logic        i_inst_ready,
  output logic        o_fault
);

  // Decode handshake: an instruction moves when o_inst_valid && i_inst_ready on a rising edge;
  // o_inst/o_inst_pc are held stable while valid and not yet accepted.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
`ifdef WARP_FETCH_MISALIGN_EN
    S_KILL,
    S_FAULT
`else
    S_KILL
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] buf_q, buf_d;
  logic [63:0] redirect_pc;

`ifdef WARP_FETCH_MISALIGN_EN
  assign redirect_pc = i_redirect_pc;
`else
  assign redirect_pc = i_redirect_pc & ~64'h3;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (i_res_valid) begin
          buf_d   = i_res_rdata;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_inst_ready) begin
          pc_d    = pc_q + 64'd4;
          state_d = pc_q[2] ? S_REQ : S_DRAIN;
        end
      end
      S_KILL: begin
        if (i_res_valid) state_d = S_REQ;
      end
`ifdef WARP_FETCH_MISALIGN_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase

    // A redirect overrides everything; a response landing in the same cycle is stale.
    if (i_redirect_valid) begin
      pc_d  = redirect_pc;
      buf_d = buf_q;
      case (state_q)
        S_REQ:          state_d = S_KILL;
        S_WAIT, S_KILL: state_d = i_res_valid ? S_REQ : S_KILL;
        default:        state_d = S_REQ;
      endcase
    end

`ifdef WARP_FETCH_MISALIGN_EN
    if (state_d == S_REQ && pc_d[1:0] != 2'b00) state_d = S_FAULT;
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      buf_q   <= 64'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  assign o_req_valid  = (state_q == S_REQ);
  assign o_req_raddr  = {pc_q[63:3], 3'b000};
  assign o_inst_valid = (state_q == S_DRAIN);
  assign o_inst       = pc_q[2] ? buf_q[63:32] : buf_q[31:0];
  assign o_inst_pc    = pc_q;
`ifdef WARP_FETCH_MISALIGN_EN
  assign o_fault      = (state_q == S_FAULT);
`else
  assign o_fault      = 1'b0;
`endif

endmodule

// File: tb/tb_warp_fetch.sv
// Scoreboard bench for warp_fetch: directed scenarios push expected requests and
// instructions; monitors pop and compare whenever the DUT presents them.
module tb_warp_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_req_valid;
  logic [63:0] o_req_raddr;
  logic        i_res_valid = 1'b0;
  logic [63:0] i_res_rdata = 64'h0;
  logic        i_redirect_valid = 1'b0;
  logic [63:0] i_redirect_pc = 64'h0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [63:0] o_inst_pc;
  logic        i_inst_ready = 1'b0;
  logic        o_fault;

  int checks = 0;
  int errors = 0;
  int lat = 3;

  logic [63:0] exp_req_q[$];
  logic [95:0] exp_inst_q[$];

  warp_fetch #(.RESET_PC(64'h0)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_req_valid(o_req_valid), .o_req_raddr(o_req_raddr),
    .i_res_valid(i_res_valid), .i_res_rdata(i_res_rdata),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .i_inst_ready(i_inst_ready), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Icache contents: doubleword 0 holds the reference pair, others encode their address.
  function automatic logic [63:0] mem_dw(input logic [63:0] a);
    if (a == 64'h0) return 64'h00000013_00100093;
    return {32'h1000_0000 + a[31:0] + 32'd4, 32'h1000_0000 + a[31:0]};
  endfunction

  // Icache responder: answers each request exactly lat cycles after the request cycle.
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [63:0] pend_addr = 64'h0;
  always @(posedge clk) begin
    #1;
    i_res_valid = 1'b0;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        i_res_valid = 1'b1;
        i_res_rdata = mem_dw(pend_addr);
        pend = 1'b0;
      end
    end
    if (o_req_valid) begin
      pend = 1'b1;
      cnt = lat;
      pend_addr = o_req_raddr;
    end
  end

  // Monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (o_req_valid) begin
        if (exp_req_q.size() == 0) chk("req_unexpected", {32'h0, o_req_raddr}, 96'hFFFF);
        else chk("req_addr", {32'h0, o_req_raddr}, {32'h0, exp_req_q.pop_front()});
      end
      if (o_inst_valid && i_inst_ready) begin
        if (exp_inst_q.size() == 0) chk("inst_unexpected", {o_inst_pc, o_inst}, 96'hFFFF);
        else chk("inst", {o_inst_pc, o_inst}, exp_inst_q.pop_front());
      end
    end
  end

  task automatic push_inst(input logic [63:0] pc, input logic [31:0] inst);
    exp_inst_q.push_back({pc, inst});
  endtask

  task automatic do_reset();
    chk("leftover_req", exp_req_q.size(), 0);
    chk("leftover_inst", exp_inst_q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    i_redirect_valid = 1'b0;
    @(negedge clk);
    chk("rst_req_valid", o_req_valid, 0);
    chk("rst_inst_valid", o_inst_valid, 0);
    chk("rst_fault", o_fault, 0);
    chk("rst_raddr", o_req_raddr, 64'h0);
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_inst_pc", o_inst_pc, 64'h0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_req_q.push_back(64'h0);
    @(negedge clk);
    chk("idle_no_req", o_req_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("first_req_valid", o_req_valid, 1);
  endtask

  // Accept instructions until the one at pc is presented, then stall it (ready low).
  task automatic run_until_inst(input logic [63:0] pc);
    logic found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (o_inst_valid && o_inst_pc == pc) begin
        i_inst_ready = 1'b0;
        found = 1'b1;
        break;
      end
      i_inst_ready = 1'b1;
    end
    if (!found) chk("run_timeout", 0, pc);
  endtask

  initial begin
    // Basic fetch and backpressure
    lat = 3;
    do_reset();
    push_inst(64'h0, 32'h00100093);
    push_inst(64'h4, 32'h00000013);
    exp_req_q.push_back(64'h8);
    push_inst(64'h8, 32'h10000008);
    push_inst(64'hC, 32'h1000000C);
    exp_req_q.push_back(64'h10);
    run_until_inst(64'h8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", o_inst_valid, 1);
      chk("bp_inst", o_inst, 32'h10000008);
      chk("bp_pc", o_inst_pc, 64'h8);
      chk("bp_no_req", o_req_valid, 0);
      @(posedge clk); #1;
    end
    i_inst_ready = 1'b1;
    run_until_inst(64'h10);

    // Redirect to 0x44 while the request for 0x0 is outstanding
    do_reset();
    @(posedge clk); #1;
    i_redirect_valid = 1'b1;
    i_redirect_pc = 64'h44;
    exp_req_q.push_back(64'h40);
    push_inst(64'h44, 32'h10000044);
    exp_req_q.push_back(64'h48);
    @(posedge clk); #1;
    i_redirect_valid = 1'b0;
    run_until_inst(64'h48);

    // Redirect to 0x80 in the same cycle as the response
    do_reset();
    repeat (3) begin @(posedge clk); #1; end
    i_redirect_valid = 1'b1;
    i_redirect_pc = 64'h80;
    exp_req_q.push_back(64'h80);
    push_inst(64'h80, 32'h10000080);
    push_inst(64'h84, 32'h10000084);
    exp_req_q.push_back(64'h88);
    @(posedge clk); #1;
    i_redirect_valid = 1'b0;
    @(negedge clk);
    chk("rdr_res_req", o_req_valid, 1);
    chk("rdr_res_no_inst", o_inst_valid, 0);
    run_until_inst(64'h88);

    // Misaligned redirect to 0x42 from a stalled DRAIN
    i_inst_ready = 1'b0;
    do_reset();
    run_until_inst(64'h0);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 64'h42;
`ifdef WARP_FETCH_MISALIGN_EN
    @(posedge clk); #1;
    i_redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fault_set", o_fault, 1);
      chk("fault_no_req", o_req_valid, 0);
      chk("fault_no_inst", o_inst_valid, 0);
      @(posedge clk); #1;
    end
    i_redirect_valid = 1'b1;
    i_redirect_pc = 64'h40;
`endif
    exp_req_q.push_back(64'h40);
    push_inst(64'h40, 32'h10000040);
    push_inst(64'h44, 32'h10000044);
    exp_req_q.push_back(64'h48);
    @(posedge clk); #1;
    i_redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_fault_clear", o_fault, 0);
    chk("mis_req_valid", o_req_valid, 1);
    run_until_inst(64'h48);

    // Reset in the middle of WAIT; stale response arrives while in IDLE
    lat = 4;
    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req", o_req_valid, 0);
    chk("midrst_inst", o_inst_valid, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_req_q.push_back(64'h0);
    @(negedge clk);
    chk("late_res_idle_req", o_req_valid, 0);
    chk("late_res_idle_inst", o_inst_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("restart_req", o_req_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("restart_wait_no_inst", o_inst_valid, 0);
    push_inst(64'h0, 32'h00100093);
    push_inst(64'h4, 32'h00000013);
    exp_req_q.push_back(64'h8);
    run_until_inst(64'h8);

    @(negedge clk);
    chk("final_req_q", exp_req_q.size(), 0);
    chk("final_inst_q", exp_inst_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_fetch.md
# warp_fetch

Instruction fetch stage that sits directly upstream of `warp_icache`. It owns the program counter and issues one doubleword read request at a time to the icache. It splits each 64-bit response into two 32-bit instructions and hands them to decode over a valid/ready handshake. Backend redirects (branches, traps) are honoured, and any in-flight icache response that became stale is discarded.

## Interface
Parameters:
- `RESET_PC`, default `64'h0`: PC loaded on reset. Must be 4-byte aligned.

Ports:
- `i_clk`, in, 1: clock; all state on rising edge.
- `i_rst`, in, 1: reset. Asynchronous and active-high.
- `o_req_valid`, out, 1: single-cycle icache request strobe.
- `o_req_raddr`, out, 64: icache byte address, always `{pc[63:3], 3'b000}`.
- `i_res_valid`, in, 1: icache response strobe (one cycle).
- `i_res_rdata`, in, 64: icache doubleword.
- `i_redirect_valid`, in, 1: backend redirect strobe.
- `i_redirect_pc`, in, 64: redirect target.
- `o_inst_valid`, out, 1: instruction available to decode.
- `o_inst`, out, 32: instruction word.
- `o_inst_pc`, out, 64: PC of `o_inst`.
- `i_inst_ready`, in, 1: decode accepts. Handshake completes when valid and ready are both high.
- `o_fault`, out, 1: misaligned-target fault (see Configuration).

## Operation
- Registers:
  - `pc[63:0]`
  - `buf[63:0]`
  - state ∈ {IDLE, REQ, WAIT, DRAIN, KILL, FAULT}
- Only one icache request is ever outstanding. A new `o_req_valid` is never raised before the previous request's `i_res_valid`.
- States:
  - **IDLE**: entered only from reset. Goes to REQ on the next edge.
  - **REQ**: `o_req_valid`=1 for exactly this cycle. Goes to WAIT.
  - **WAIT**: on `i_res_valid`, set `buf`←`i_res_rdata` and go to DRAIN.
  - **DRAIN**: `o_inst_valid`=1.
    - `o_inst` = `pc[2]` ? `buf[63:32]` : `buf[31:0]` (little-endian).
    - `o_inst_pc` = `pc`.
    - On handshake: `pc`←`pc+4` (64-bit wrap). If the old `pc[2]` was 0, stay in DRAIN; otherwise go to REQ.
  - **KILL**: a request is in flight for a stale PC. On `i_res_valid`, discard the data and go to REQ.
  - **FAULT**: see Configuration.
- Redirect has priority over every other transition. It always sets `pc`←target. Next state by current state:
  - From IDLE, REQ-less DRAIN, or FAULT: go to REQ.
  - From REQ: the request was already issued this cycle, so go to KILL.
  - From WAIT without `i_res_valid`: go to KILL.
  - From WAIT with simultaneous `i_res_valid`: discard the response and go to REQ.
  - From KILL without `i_res_valid`: stay in KILL.
  - From KILL with `i_res_valid`: go to REQ.
- Redirect and handshake in the same DRAIN cycle: the instruction counts as consumed, and `pc` takes the redirect target (not `pc+4`).
- `o_inst_valid` is held while `i_inst_ready`=0. `o_inst` and `o_inst_pc` are stable while valid and unaccepted.

## Timing
- Reset values:
  - `o_req_valid`=0, `o_inst_valid`=0, `o_fault`=0.
  - `o_req_raddr`=`{RESET_PC[63:3],000}`.
  - `o_inst`=0, `o_inst_pc`=`RESET_PC`.
  - state=IDLE, `buf`=0.
- Reset mid-operation aborts immediately. Any later `i_res_valid` that arrives while in IDLE is ignored.
- After reset release, the first rising edge enters REQ, so `o_req_valid` is high during the second cycle.
- `o_inst_valid` rises on the edge after the `i_res_valid` cycle (1-cycle latency).
- Best case with decode always ready and an icache response after N cycles:
  - doubleword period = 1 (REQ) + N (WAIT) + 2 (DRAIN) cycles for an aligned start;
  - 1 DRAIN cycle when entry is at `pc[2]`=1.
- A redirect takes effect on the next edge. `o_req_valid` for the target appears one cycle after the redirect, or one cycle after the stale response drains.
- All outputs are decoded from registered state and `buf`/`pc`, with no combinational path from inputs to outputs.

## Configuration
- `WARP_FETCH_MISALIGN_EN` defined:
  - A redirect with `i_redirect_pc[1:0]`≠0 loads `pc` unmodified.
  - Entry to REQ is replaced by entry to FAULT; from KILL this happens once the stale response drains.
  - In FAULT: `o_fault`=1, with no requests and no instructions. The block leaves FAULT only on an aligned redirect (goes to REQ) or on reset.
- Macro undefined:
  - `pc`←`{i_redirect_pc[63:2], 2'b00}`.
  - The FAULT state is not built, and `o_fault` is tied to 0.

## Test plan
- Reset with `RESET_PC`=0 and an icache responding in 3 cycles with `64'h00000013_00100093`, decode always ready:
  - the request at 0x0 is issued in the second cycle after release;
  - decode then receives `00100093`@0x0 followed by `00000013`@0x4;
  - the next request is at 0x8.
- Backpressure: hold `i_inst_ready`=0 for 5 cycles in DRAIN. `o_inst` and `o_inst_pc` must not change, and no request may be issued.
- Redirect to 0x44 during WAIT (request for 0x0 outstanding):
  - the response to 0x0 is discarded;
  - the next request is at 0x40;
  - the first instruction delivered is `buf[63:32]` @0x44.
- Redirect to 0x80 coinciding with `i_res_valid` in WAIT: the data is discarded and the request at 0x80 is issued on the next cycle, with no instruction delivered in between.
- With `WARP_FETCH_MISALIGN_EN`, redirect to 0x42:
  - `o_fault`=1 and no requests are issued;
  - a later redirect to 0x40 clears `o_fault` and issues a request at 0x40.
  - Without the macro, the same redirect to 0x42 fetches 0x40, with `o_inst_pc`=0x40.
- Assert `i_rst` in the middle of a WAIT, then return a late `i_res_valid` after release. The late response is ignored and fetch restarts at `RESET_PC`.
